// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer arbiter.
//   FB_W/FB_H     : framebuffer size in cells
//   ADDR_W        : RAM address width
//   SCALE_LOG2    : log2 of pixels per cell per axis
//   FB_SIZE       : number of cells, FB_LAST is the highest valid address
//   clr_state_e   : clear engine states
package vga_fb_arbiter_pkg;

    localparam int unsigned FB_W       = 160;
    localparam int unsigned FB_H       = 120;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned SCALE_LOG2 = 2;
    localparam int unsigned FB_SIZE    = FB_W * FB_H;

    localparam logic [ADDR_W-1:0] FB_SIZE_A = ADDR_W'(FB_SIZE);
    localparam logic [ADDR_W-1:0] FB_LAST   = ADDR_W'(FB_SIZE - 1);

    // RRRGGGBB colour layout
    localparam int unsigned RED_W = 3;
    localparam int unsigned GRN_W = 3;
    localparam int unsigned BLU_W = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StClear = 2'd2
    } clr_state_e;

endpackage

// File: rtl/vga_fb_addr.sv
// Maps a pixel coordinate to its framebuffer cell address.
//   i_x, i_y    : pixel column / row
//   o_addr      : (y>>2)*FB_W + (x>>2)
//   o_in_range  : cell lies inside the FB_W x FB_H buffer
module vga_fb_addr
    import vga_fb_arbiter_pkg::*;
(
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_range
);

    localparam int unsigned CW = 10 - SCALE_LOG2;
    localparam logic [CW-1:0] CELLS_X = CW'(FB_W);
    localparam logic [CW-1:0] CELLS_Y = CW'(FB_H);

    logic [CW-1:0]     w_cx;
    logic [CW-1:0]     w_cy;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_y_ext;
    logic              w_unused;

    assign w_cx     = i_x[9:SCALE_LOG2];
    assign w_cy     = i_y[9:SCALE_LOG2];
    assign w_unused = ^{i_x[SCALE_LOG2-1:0], i_y[SCALE_LOG2-1:0]};

    assign w_x_ext = ADDR_W'(w_cx);
    assign w_y_ext = ADDR_W'(w_cy);

    // y*160 as y*128 + y*32; only meaningful for FB_W == 160
    assign o_addr     = (w_y_ext << 7) + (w_y_ext << 5) + w_x_ext;
    assign o_in_range = (w_cx < CELLS_X) && (w_cy < CELLS_Y);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display scanout > clear engine > writer.
//   clk, rst_n                    : pixel clock, async active-low reset
//   pix_active/pix_x/pix_y        : timing generator position
//   frame_start                   : starts an armed clear
//   pix_color                     : cell colour, 2 cycles after pix_x/pix_y
//   wr_valid/wr_ready/wr_addr/... : drawing writer handshake
//   clear_req/clear_color         : arm a full-buffer fill
//   clear_busy/clear_done         : clear status
//   err_addr/err_clr              : sticky address error flag and its clear
//   mem_*                         : RAM port, read data one cycle after enable
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_active,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              frame_start,
    output logic [7:0]        pix_color,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clear_req,
    input  logic [7:0]        clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              err_addr,
    input  logic              err_clr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_in_range;
    logic              w_slot;
    logic              w_rd;
    logic              w_oor;
    logic              w_clr_wr;
    logic              w_last;
    logic              w_wr_acc;
    logic              w_wr_ok;
    logic              w_wr_bad;

    clr_state_e        r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [7:0]        r_clr_color;
    logic              r_busy;
    logic              r_done;
    logic              r_act_d1;
    logic              r_act_d2;
    logic              r_slot_d1;
    logic              r_rd_d1;
    logic [7:0]        r_color;
    logic              r_err;

    vga_fb_addr u_addr (
        .i_x        (pix_x),
        .i_y        (pix_y),
        .o_addr     (w_disp_addr),
        .o_in_range (w_in_range)
    );

    // The display owns the first cycle of every 4-pixel group, even when the
    // group is off the buffer and no read is issued.
    assign w_slot   = pix_active && (pix_x[SCALE_LOG2-1:0] == '0);
    assign w_rd     = w_slot && w_in_range;
    assign w_oor    = pix_active && !w_in_range;
    assign w_clr_wr = !w_slot && (r_state == StClear);
    assign w_last   = w_clr_wr && (r_clr_addr == FB_LAST);

    assign wr_ready = rst_n && !w_slot && (r_state == StIdle);
    assign w_wr_acc = wr_valid && wr_ready;
    assign w_wr_ok  = w_wr_acc && (wr_addr < FB_SIZE_A);
    assign w_wr_bad = w_wr_acc && !(wr_addr < FB_SIZE_A);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (w_rd) begin
                mem_en   = 1'b1;
                mem_addr = w_disp_addr;
            end else if (w_clr_wr) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_clr_addr;
                mem_wdata = r_clr_color;
            end else if (w_wr_ok) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end
        end
    end

    // Clear engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (clear_req) begin
                        r_state     <= StArmed;
                        r_clr_color <= clear_color;
                        r_busy      <= 1'b1;
                    end
                end
                StArmed: begin
                    if (frame_start) begin
                        r_state    <= StClear;
                        r_clr_addr <= '0;
                    end
                end
                StClear: begin
                    if (w_last) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_clr_wr) begin
                        r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scanout: read at T, data on mem_rdata at T+1, shown from T+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_d1  <= 1'b0;
            r_act_d2  <= 1'b0;
            r_slot_d1 <= 1'b0;
            r_rd_d1   <= 1'b0;
            r_color   <= '0;
        end else begin
            r_act_d1  <= pix_active;
            r_act_d2  <= r_act_d1;
            r_slot_d1 <= w_slot;
            r_rd_d1   <= w_rd;
            // An off-buffer group loads black rather than keeping stale colour
            if (r_slot_d1) begin
                r_color <= r_rd_d1 ? mem_rdata : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_wr_bad || w_oor) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign pix_color  = r_act_d2 ? r_color : 8'h00;
    assign clear_busy = r_busy;
    assign clear_done = r_done;
    assign err_addr   = r_err;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pix_active;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic [7:0]  pix_color;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        clear_busy;
    logic        clear_done;
    logic        err_addr;
    logic        err_clr;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    vga_fb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_active  (pix_active),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .pix_color   (pix_color),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .err_addr    (err_addr),
        .err_clr     (err_clr),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM attached to the DUT
    logic [7:0] ram [0:32767];
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 8'(i * 37 + 11);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic ready;
        logic en;
        logic err;
        logic busy;
        logic done;
    } cyc_t;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
    } acc_t;

    cyc_t       cyc_q[$];
    acc_t       acc_q[$];
    logic [7:0] pix_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    // Reference model: cell contents and what the arbiter owes each user
    logic [7:0] ref_mem [0:19199];
    bit         m_armed, m_clearing, m_err, m_done, m_in_reset;
    int         m_clr_addr;
    logic [7:0] m_clr_color;
    logic [7:0] m_grp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor
    cyc_t       mc;
    acc_t       ma;
    logic [7:0] mp;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            chk("wr_ready",   32'(wr_ready),   32'(mc.ready));
            chk("mem_en",     32'(mem_en),     32'(mc.en));
            chk("err_addr",   32'(err_addr),   32'(mc.err));
            chk("clear_busy", 32'(clear_busy), 32'(mc.busy));
            chk("clear_done", 32'(clear_done), 32'(mc.done));
        end
        if (pix_q.size() > 0) begin
            mp = pix_q.pop_front();
            chk("pix_color", 32'(pix_color), 32'(mp));
        end
        if (clear_done) done_seen++;
        if (mem_en) begin
            if (acc_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_access: got addr %0d we %0b, want none at %0t",
                         mem_addr, mem_we, $time);
            end else begin
                ma = acc_q.pop_front();
                chk("mem_we",   32'(mem_we),   32'(ma.we));
                chk("mem_addr", 32'(mem_addr), 32'(ma.addr));
                if (ma.we) chk("mem_wdata", 32'(mem_wdata), 32'(ma.data));
            end
        end
    end

    // Advance one cycle: record what the spec demands for the inputs now
    // applied, then update the model's view of state.
    task automatic tick();
        int   cx, cy, a;
        bit   slot, inr, rdy, clr_wr, wr_acc, wr_ok, last;
        cyc_t c;
        acc_t e;
        wr_acc = 0;
        if (!rst_n) begin
            if (!m_in_reset) begin
                pix_q.delete();
                pix_q.push_back(8'h00);
                pix_q.push_back(8'h00);
            end
            m_in_reset = 1;
            c = '0;
            cyc_q.push_back(c);
            pix_q.push_back(8'h00);
            m_armed = 0; m_clearing = 0; m_err = 0; m_done = 0; m_grp = 8'h00;
            m_clr_addr = 0;
        end else begin
            m_in_reset = 0;
            cx     = int'(pix_x) / 4;
            cy     = int'(pix_y) / 4;
            slot   = pix_active && (int'(pix_x) % 4 == 0);
            inr    = (cx < 160) && (cy < 120);
            rdy    = !slot && !m_armed && !m_clearing;
            clr_wr = !slot && m_clearing;
            wr_acc = rdy && wr_valid;
            wr_ok  = wr_acc && (int'(wr_addr) < 19200);
            c.ready = rdy;
            c.en    = (slot && inr) || clr_wr || wr_ok;
            c.err   = m_err;
            c.busy  = m_armed || m_clearing;
            c.done  = m_done;
            cyc_q.push_back(c);
            if (slot) begin
                if (inr) begin
                    a = cy * 160 + cx;
                    e.we = 1'b0; e.addr = 15'(a); e.data = 8'h00;
                    acc_q.push_back(e);
                    m_grp = ref_mem[a];
                end else begin
                    m_grp = 8'h00;
                end
            end
            pix_q.push_back(pix_active ? m_grp : 8'h00);
            last = 0;
            if (clr_wr) begin
                e.we = 1'b1; e.addr = 15'(m_clr_addr); e.data = m_clr_color;
                acc_q.push_back(e);
                ref_mem[m_clr_addr] = m_clr_color;
                if (m_clr_addr == 19199) last = 1;
                else m_clr_addr++;
            end else if (wr_ok) begin
                e.we = 1'b1; e.addr = wr_addr; e.data = wr_data;
                acc_q.push_back(e);
                ref_mem[int'(wr_addr)] = wr_data;
            end
            if ((wr_acc && !wr_ok) || (pix_active && !inr)) m_err = 1;
            else if (err_clr) m_err = 0;
            m_done = last;
            if (last) begin
                m_clearing = 0;
            end else if (m_armed && frame_start) begin
                m_armed = 0; m_clearing = 1; m_clr_addr = 0;
            end else if (!m_armed && !m_clearing && clear_req) begin
                m_armed = 1; m_clr_color = clear_color;
            end
        end
        @(posedge clk);
        #1;
        if (wr_acc) wr_valid = 1'b0;
        frame_start = 1'b0;
        clear_req   = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic set_pix(input bit act, input int x, input int y);
        pix_active = act;
        pix_x      = 10'(x);
        pix_y      = 10'(y);
    endtask

    task automatic maybe_wr(input int prob);
        if (!wr_valid && int'($urandom_range(0, 99)) < prob) begin
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) wr_addr = 15'(19200 + $urandom_range(0, 13567));
            else                            wr_addr = 15'($urandom_range(0, 19199));
        end
    endtask

    // One 4-pixel group at cell column gx on pixel row y
    task automatic group(input bit act, input int gx, input int y, input int wprob);
        for (int i = 0; i < 4; i++) begin
            maybe_wr(wprob);
            set_pix(act, gx * 4 + i, y);
            tick();
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            set_pix(0, 0, 0);
            tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && wr_valid; i++) blank(1);
    endtask

    int guard;

    initial begin
        rst_n = 1'b0; ram_init = 1'b1;
        pix_active = 1'b0; pix_x = '0; pix_y = '0; frame_start = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clear_req = 1'b0; clear_color = '0; err_clr = 1'b0;
        m_armed = 0; m_clearing = 0; m_err = 0; m_done = 0; m_in_reset = 0;
        m_clr_addr = 0; m_clr_color = '0; m_grp = '0;
        for (int i = 0; i < 19200; i++) ref_mem[i] = 8'(i * 37 + 11);
        @(posedge clk);
        #1;
        ram_init = 1'b0;

        // Reset held mid-frame with traffic pending: everything stays quiet
        wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 8'h77;
        clear_req = 1'b1; clear_color = 8'h33;
        for (int i = 0; i < 4; i++) begin
            set_pix(1, 40 + i, 40);
            tick();
        end
        rst_n = 1'b1;

        // First line from the origin, light writer traffic
        for (int g = 0; g < 16; g++) group(1, g, 0, 30);
        drain();

        // Preload cell 162 and scan it at x=8..11, y=4
        wr_valid = 1'b1; wr_addr = 15'd162; wr_data = 8'hE3;
        blank(1);
        group(1, 2, 4, 0);
        blank(4);

        // Writer held valid through a whole active line
        for (int g = 0; g < 160; g++) group(1, g, 8, 100);
        drain();

        // Bad writer address, sticky error, then clear it
        wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 8'h5A;
        blank(4);
        err_clr = 1'b1;
        blank(2);

        // Random traffic including off-buffer groups
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) err_clr = 1'b1;
            if ($urandom_range(0, 29) == 0) frame_start = 1'b1;
            group($urandom_range(0, 3) != 0, $urandom_range(0, 169), $urandom_range(0, 489), 40);
        end
        drain();
        err_clr = 1'b1;
        blank(1);

        // Clear: same-cycle frame_start is ignored, re-request is ignored
        clear_req = 1'b1; clear_color = 8'h1C; frame_start = 1'b1;
        blank(1);
        clear_color = 8'h00;
        for (int g = 0; g < 25; g++) begin
            if (g == 10) begin clear_req = 1'b1; clear_color = 8'hFF; end
            group(1, g, 12, 100);
        end
        frame_start = 1'b1;
        blank(1);
        guard = 0;
        while (m_clearing && guard < 40000) begin
            group($urandom_range(0, 3) != 0, $urandom_range(0, 159), $urandom_range(0, 479), 50);
            guard += 4;
        end
        blank(4);
        drain();

        // Clear aborted by reset, then a fresh clear from address 0
        clear_req = 1'b1; clear_color = 8'hAA;
        blank(1);
        frame_start = 1'b1;
        blank(1);
        guard = 0;
        while (m_clearing && m_clr_addr != 5000 && guard < 10000) begin
            blank(1);
            guard++;
        end
        rst_n = 1'b0;
        blank(3);
        rst_n = 1'b1;
        blank(2);
        clear_req = 1'b1; clear_color = 8'h55;
        blank(1);
        frame_start = 1'b1;
        blank(1);
        guard = 0;
        while (m_clearing && guard < 25000) begin
            blank(1);
            guard++;
        end
        blank(3);
        for (int n = 0; n < 40; n++) begin
            group(1, $urandom_range(0, 159), $urandom_range(0, 479), 20);
        end
        drain();
        blank(4);

        chk("clear_done_pulses", 32'(done_seen), 32'd2);
        chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
